// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and downstream reset sequencer; RUN is entered 2+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES edges after lock is first sampled.
// No backpressure; PLL_RESET_SEQ_LOSS_COUNT_EN adds a saturating count of lock losses seen in RUN.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_COUNT_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pll_lock,
    output logic                        sys_rst,
    output logic                        ready,
    output logic [1:0]                  state,
    output logic [LOSS_COUNT_WIDTH-1:0] loss_count
);

    localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lock_m;
    logic          lock_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            cur_state <= WAIT_LOCK;
            cnt_q     <= '0;
        end else begin
            lock_m    <= pll_lock;
            lock_s    <= lock_m;
            cur_state <= nxt_state;
            cnt_q     <= cnt_d;
        end
    end

    // Lock-low is tested first in every state so it always beats count expiry.
    always_comb begin
        nxt_state = cur_state;
        cnt_d     = cnt_q;
        case (cur_state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    nxt_state = STABLE;
                    cnt_d     = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    nxt_state = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    nxt_state = HOLD;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    nxt_state = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    nxt_state = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    nxt_state = WAIT_LOCK;
                end
            end
            default: nxt_state = WAIT_LOCK;
        endcase
    end

    assign state   = cur_state;
    assign ready   = (cur_state == RUN);
    assign sys_rst = ~ready;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic                        loss_event;
    logic [LOSS_COUNT_WIDTH-1:0] loss_q;

    assign loss_event = (cur_state == RUN) && !lock_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_event && (loss_q != '1)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: run-length reference model checked every cycle, directed timing pins, then random lock/reset traffic.
module tb_pll_reset_sequencer;

    localparam int L     = 4;
    localparam int H     = 3;
    localparam int W     = 2;
    localparam int RUN_K = L + H;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pll_lock = 1'b0;
    logic         sys_rst;
    logic         ready;
    logic [1:0]   state;
    logic [W-1:0] loss_count;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .RESET_HOLD_CYCLES (H),
        .LOSS_COUNT_WIDTH  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .state     (state),
        .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: k = consecutive edges at which the FSM has seen synchronized lock high.
    int s1 = 0, s2 = 0, k = 0, mloss = 0, obs = 0;
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            s1 = 0; s2 = 0; k = 0; mloss = 0; mvalid = 1'b1;
        end else begin
            obs = s2;
            s2  = s1;
            s1  = int'(pll_lock);
            if (obs != 0) begin
                if (k <= RUN_K) k++;
            end else begin
                if (k > RUN_K && mloss < (1 << W) - 1) mloss++;
                k = 0;
            end
        end
    end

    function automatic int exp_state(input int kk);
        if (kk == 0) return 0;
        if (kk <= L) return 1;
        if (kk <= RUN_K) return 2;
        return 3;
    endfunction

    function automatic int exp_loss(input int m);
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
        return m;
`else
        return 0 * m;
`endif
    endfunction

    always @(negedge clk) begin
        if (mvalid) begin
            check("model_state",   32'(state),      32'(exp_state(k)));
            check("model_sys_rst", 32'(sys_rst),    32'(exp_state(k) != 3));
            check("model_ready",   32'(ready),      32'(exp_state(k) == 3));
            check("model_loss",    32'(loss_count), 32'(exp_loss(mloss)));
        end
    end

    logic [1:0] seq [16];

    task automatic step(input logic r, input logic l);
        @(negedge clk);
        #1;
        rst      = r;
        pll_lock = l;
    endtask

    // Raises lock; n = index of the edge (first lock-sampling edge is 0) at which ready rises.
    task automatic relock(output int n);
        step(1'b0, 1'b1);
        n = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            seq[(i < 16) ? i : 15] = state;
            if (ready === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic drop(output int n);
        step(1'b0, 1'b0);
        n = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (sys_rst === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] s);
        int found;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (state === s) begin
                found = 1;
                break;
            end
        end
        check("reach_state", 32'(found), 32'd1);
    endtask

    int n;
    int exp_losses [5];
    logic [1:0] exp_seq [10];
    logic lk;

    initial begin
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
        exp_losses = '{1, 2, 3, 3, 3};
`else
        exp_losses = '{0, 0, 0, 0, 0};
`endif
        exp_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};

        // Power-up
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",   32'(state),      32'd0);
        check("rst_sys_rst", 32'(sys_rst),    32'd1);
        check("rst_ready",   32'(ready),      32'd0);
        check("rst_loss",    32'(loss_count), 32'd0);
        relock(n);
        check("powerup_run_edge", 32'(n), 32'd9);
        for (int i = 0; i < 10; i++) check("powerup_seq", 32'(seq[i]), 32'(exp_seq[i]));

        // Losses from RUN, including saturation
        for (int j = 0; j < 5; j++) begin
            drop(n);
            check("loss_sys_rst_edge", 32'(n), 32'd2);
            check("loss_count_seq", 32'(loss_count), 32'(exp_losses[j]));
            repeat (2) step(1'b0, 1'b0);
            relock(n);
            check("relock_run_edge", 32'(n), 32'd9);
        end

        // One-cycle glitch during STABLE
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        wait_state(2'd1);
        step(1'b0, 1'b0);
        relock(n);
        check("glitch_back_to_wait", 32'(seq[1]), 32'd0);
        check("glitch_run_edge", 32'(n), 32'd9);
        check("glitch_loss", 32'(loss_count), 32'd0);

        // Reset while in HOLD
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        wait_state(2'd2);
        step(1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("hold_rst_state",   32'(state),      32'd0);
        check("hold_rst_sys_rst", 32'(sys_rst),    32'd1);
        check("hold_rst_loss",    32'(loss_count), 32'd0);
        relock(n);
        check("hold_rst_run_edge", 32'(n), 32'd9);

        // Random lock flapping with occasional resets
        lk = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 24) == 0) lk = ~lk;
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, lk);
        end
        repeat (3) step(1'b0, lk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The module SHALL have parameter LOCK_STABLE_CYCLES, default 1024, the number of consecutive synchronized lock-high cycles required before the hold phase starts (legal range 1 or more).
REQ-002 The module SHALL have parameter RESET_HOLD_CYCLES, default 16, the number of cycles sys_rst is held after lock is stable (legal range 1 or more).
REQ-003 The module SHALL have parameter LOSS_COUNT_WIDTH, default 8, the width of the lock-loss counter.
REQ-004 The module SHALL have port clk, input, width 1: the single clock, which is the PLL output clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-006 The module SHALL have port pll_lock, input, width 1: the PLL LOCK output, asynchronous to clk.
REQ-007 The module SHALL have port sys_rst, output, width 1: synchronous active-high reset for downstream logic.
REQ-008 The module SHALL have port ready, output, width 1: high only in state RUN.
REQ-009 The module SHALL have port state, output, width 2: encoded as WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
REQ-010 The module SHALL have port loss_count, output, width LOSS_COUNT_WIDTH: the number of lock losses observed in RUN.

Function
REQ-011 pll_lock SHALL pass through a two-flop synchronizer; its second flop is lock_s, giving 2 edges of latency.
REQ-012 WAIT_LOCK: when lock_s=1, the next state SHALL be STABLE and cnt SHALL be set to 0; otherwise the state holds.
REQ-013 STABLE: if lock_s=0, the next state SHALL be WAIT_LOCK; if cnt=LOCK_STABLE_CYCLES-1, the next state SHALL be HOLD with cnt=0; otherwise cnt SHALL increment.
REQ-014 HOLD: if lock_s=0, the next state SHALL be WAIT_LOCK; if cnt=RESET_HOLD_CYCLES-1, the next state SHALL be RUN; otherwise cnt SHALL increment.
REQ-015 RUN: if lock_s=0, the next state SHALL be WAIT_LOCK and a loss event SHALL be recorded; otherwise the state holds.
REQ-016 Lock-low SHALL take priority over count expiry whenever both occur in the same cycle.
REQ-017 sys_rst SHALL be 0 only in RUN, and ready SHALL equal (state==RUN); both SHALL be decoded from the state register with no added latency.
REQ-018 cnt SHALL be wide enough for max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)-1 and SHALL never wrap.
REQ-019 A loss event SHALL increment loss_count, saturating at all-ones.
REQ-020 A lock drop in STABLE or HOLD SHALL restart qualification and SHALL NOT count as a loss.
REQ-021 From the first edge E0 that samples pll_lock=1, RUN SHALL be entered at edge E(2+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES), provided lock stays high.

Reset
REQ-022 While rst=1 at an edge: state=WAIT_LOCK, cnt=0, synchronizer flops=0, loss_count=0, sys_rst=1, ready=0.
REQ-023 rst asserted mid-sequence or in RUN SHALL abort immediately to the values in REQ-022 and SHALL NOT record a loss.
REQ-024 After rst is released, sequencing SHALL restart from WAIT_LOCK with full synchronizer latency.

Configuration
REQ-025 Macro PLL_RESET_SEQ_LOSS_COUNT_EN: when defined, the loss counter SHALL be implemented per REQ-019.
REQ-026 When PLL_RESET_SEQ_LOSS_COUNT_EN is undefined, loss_count SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification (LOCK_STABLE_CYCLES=4, RESET_HOLD_CYCLES=3, LOSS_COUNT_WIDTH=2, macro defined)
REQ-027 Power-up: rst high for 3 cycles then low, pll_lock=1 from the first sampled edge after release -> state 0,1,2,3 in order; sys_rst falls and ready rises exactly 9 edges after the first sampling edge.
REQ-028 Glitch in STABLE: pll_lock low for 1 cycle during STABLE -> return to WAIT_LOCK; RUN is reached 9 edges after lock is re-sampled high; loss_count=0.
REQ-029 Loss in RUN: pll_lock drops -> sys_rst=1 and loss_count=1 at the 2nd edge after sampling; relock reaches RUN again after 9 edges.
REQ-030 Saturation: 5 lock losses, each from RUN -> loss_count reads 1,2,3,3,3.
REQ-031 Reset in HOLD: assert rst while state=2 -> state=0 and sys_rst=1 on the next edge; loss_count unchanged; re-sequencing takes 9 edges.
REQ-032 Macro undefined: rerun REQ-029 -> loss_count stays 0; state and sys_rst timing are identical to the defined case.
